// File: rtl/jtag_tap_sampled.sv
// IEEE 1149.1 TAP for a bit-banged TCK that is a plain level in the clk_i domain.
// TCK edges are found against a one-cycle-delayed copy; all TAP activity happens on those edge cycles.
module jtag_tap_sampled #(
    parameter int unsigned       IR_LEN     = 5,
    parameter logic [31:0]       IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_LEN-1:0] USER_INSTR = IR_LEN'(2)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        jtag_tck_i,
    input  logic        jtag_tms_i,
    input  logic        jtag_tdi_i,
    input  logic        jtag_trst_i,
    output logic        jtag_tdo_o,
    output logic [31:0] user_dr_o,
    output logic        user_dr_valid_o,
    input  logic [31:0] user_dr_i,
    output logic        tap_reset_o
);

    // state               | meaning
    // TLR / RTI           | test-logic-reset / run-test-idle
    // SEL_DR / SEL_IR     | select DR or IR scan column
    // CAP_* / SHIFT_*     | capture into, then shift, the DR or IR shift register
    // EXIT1_* / PAUSE_* / EXIT2_* | suspend path around shift
    // UPD_*               | transfer shift register to its holding register
    localparam logic [3:0] TLR      = 4'h0;
    localparam logic [3:0] RTI      = 4'h1;
    localparam logic [3:0] SEL_DR   = 4'h2;
    localparam logic [3:0] CAP_DR   = 4'h3;
    localparam logic [3:0] SHIFT_DR = 4'h4;
    localparam logic [3:0] EXIT1_DR = 4'h5;
    localparam logic [3:0] PAUSE_DR = 4'h6;
    localparam logic [3:0] EXIT2_DR = 4'h7;
    localparam logic [3:0] UPD_DR   = 4'h8;
    localparam logic [3:0] SEL_IR   = 4'h9;
    localparam logic [3:0] CAP_IR   = 4'hA;
    localparam logic [3:0] SHIFT_IR = 4'hB;
    localparam logic [3:0] EXIT1_IR = 4'hC;
    localparam logic [3:0] PAUSE_IR = 4'hD;
    localparam logic [3:0] EXIT2_IR = 4'hE;
    localparam logic [3:0] UPD_IR   = 4'hF;

    localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(1);
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

    logic              tck_q;
    logic              rise;
    logic              fall;
    logic [3:0]        state_q;
    logic [3:0]        state_d;
    logic [3:0]        tap_next;
    logic [IR_LEN-1:0] ir_q;
    logic [IR_LEN-1:0] ir_d;
    logic [IR_LEN-1:0] ir_sr_q;
    logic [IR_LEN-1:0] ir_sr_d;
    logic [31:0]       dr_sr_q;
    logic [31:0]       dr_sr_d;
    logic              bypass_q;
    logic              bypass_d;
    logic [31:0]       user_dr_q;
    logic [31:0]       user_dr_d;
    logic              user_valid_q;
    logic              user_valid_d;
    logic              tdo_q;
    logic              tdo_d;
    logic              tap_reset_q;
    logic              tap_reset_d;
    logic              sel_idcode;
    logic              sel_user;
    logic              sel_wide;

    assign rise = jtag_tck_i & ~tck_q;
    assign fall = ~jtag_tck_i & tck_q;

    // IDCODE wins if USER_INSTR is ever set to the IDCODE opcode
    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = (ir_q == USER_INSTR) && !sel_idcode;
    assign sel_wide   = sel_idcode || sel_user;

    always_comb begin
        tap_next = state_q;
        case (state_q)
            TLR:      tap_next = jtag_tms_i ? TLR      : RTI;
            RTI:      tap_next = jtag_tms_i ? SEL_DR   : RTI;
            SEL_DR:   tap_next = jtag_tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   tap_next = jtag_tms_i ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: tap_next = jtag_tms_i ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: tap_next = jtag_tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: tap_next = jtag_tms_i ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: tap_next = jtag_tms_i ? UPD_DR   : SHIFT_DR;
            UPD_DR:   tap_next = jtag_tms_i ? SEL_DR   : RTI;
            SEL_IR:   tap_next = jtag_tms_i ? TLR      : CAP_IR;
            CAP_IR:   tap_next = jtag_tms_i ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: tap_next = jtag_tms_i ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: tap_next = jtag_tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: tap_next = jtag_tms_i ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: tap_next = jtag_tms_i ? UPD_IR   : SHIFT_IR;
            UPD_IR:   tap_next = jtag_tms_i ? SEL_DR   : RTI;
            default:  tap_next = TLR;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        ir_sr_d      = ir_sr_q;
        dr_sr_d      = dr_sr_q;
        bypass_d     = bypass_q;
        user_dr_d    = user_dr_q;
        user_valid_d = 1'b0;

        if (jtag_trst_i) begin
            state_d = TLR;
            ir_d    = IR_IDCODE;
        end else if (rise) begin
            case (state_q)
                CAP_IR:   ir_sr_d = IR_CAPTURE;
                SHIFT_IR: ir_sr_d = {jtag_tdi_i, ir_sr_q[IR_LEN-1:1]};
                UPD_IR:   ir_d    = ir_sr_q;
                CAP_DR: begin
                    if (sel_idcode) begin
                        dr_sr_d = IDCODE_VAL;
                    end else if (sel_user) begin
                        dr_sr_d = user_dr_i;
                    end else begin
                        bypass_d = 1'b0;
                    end
                end
                SHIFT_DR: begin
                    if (sel_wide) begin
                        dr_sr_d = {jtag_tdi_i, dr_sr_q[31:1]};
                    end else begin
                        bypass_d = jtag_tdi_i;
                    end
                end
                UPD_DR: begin
                    if (sel_user) begin
                        user_dr_d    = dr_sr_q;
                        user_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
            state_d = tap_next;
        end

        if (state_q == TLR) begin
            ir_d = IR_IDCODE;
        end
    end

    // TDO moves only on TCK fall so the server sees a settled level while TCK is low
    always_comb begin
        tdo_d = tdo_q;
        if (fall) begin
            case (state_q)
                SHIFT_IR: tdo_d = ir_sr_q[0];
                SHIFT_DR: tdo_d = sel_wide ? dr_sr_q[0] : bypass_q;
                default:  tdo_d = 1'b0;
            endcase
        end
    end

    assign tap_reset_d = (state_d == TLR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_q        <= 1'b0;
            state_q      <= TLR;
            ir_q         <= IR_IDCODE;
            ir_sr_q      <= '0;
            dr_sr_q      <= '0;
            bypass_q     <= 1'b0;
            user_dr_q    <= '0;
            user_valid_q <= 1'b0;
            tdo_q        <= 1'b0;
            tap_reset_q  <= 1'b1;
        end else begin
            tck_q        <= jtag_tck_i;
            state_q      <= state_d;
            ir_q         <= ir_d;
            ir_sr_q      <= ir_sr_d;
            dr_sr_q      <= dr_sr_d;
            bypass_q     <= bypass_d;
            user_dr_q    <= user_dr_d;
            user_valid_q <= user_valid_d;
            tdo_q        <= tdo_d;
            tap_reset_q  <= tap_reset_d;
        end
    end

    assign jtag_tdo_o      = tdo_q;
    assign user_dr_o       = user_dr_q;
    assign user_dr_valid_o = user_valid_q;
    assign tap_reset_o     = tap_reset_q;

endmodule

// File: doc/jtag_tap_sampled.md
JTAG_TAP_SAMPLED -- requirements
Module: jtag_tap_sampled

Interface
REQ-001 SHALL have parameter IR_LEN, default 5, instruction register width (minimum 2).
REQ-002 SHALL have parameter IDCODE_VAL, default 32'h1000_0001, IDCODE register content; bit 0 SHALL be 1.
REQ-003 SHALL have parameter USER_INSTR, default 5'h02, opcode selecting the user data register.
REQ-004 SHALL have port clk_i  input  1  system clock; all inputs sampled and all state updated on its rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port jtag_tck_i  input  1  bit-banged TCK, a level driven in the clk_i domain.
REQ-007 SHALL have port jtag_tms_i  input  1  TMS level.
REQ-008 SHALL have port jtag_tdi_i  input  1  TDI level.
REQ-009 SHALL have port jtag_trst_i  input  1  test reset, active-high, level.
REQ-010 SHALL have port jtag_tdo_o  output  1  TDO level, returned to the bit-bang server.
REQ-011 SHALL have port user_dr_o  output  32  last value written through Update-DR under USER_INSTR.
REQ-012 SHALL have port user_dr_valid_o  output  1  single-clk_i pulse when user_dr_o is updated.
REQ-013 SHALL have port user_dr_i  input  32  value captured into the user shift register in Capture-DR.
REQ-014 SHALL have port tap_reset_o  output  1  high while the TAP is in Test-Logic-Reset.

Function
REQ-015 SHALL register jtag_tck_i each clk_i cycle as tck_q; rise = tck_i & ~tck_q; fall = ~tck_i & tck_q.
REQ-016 SHALL NOT synchronise jtag_* inputs; they are already in the clk_i domain.
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on rise according to jtag_tms_i, with the new state visible one clk_i cycle after the rise cycle.
REQ-018 SHALL hold state, shift registers and TDO in cycles with neither rise nor fall.
REQ-019 Capture-IR on rise SHALL load the IR shift register with {IR_LEN-2 zeros, 2'b01}.
REQ-020 Shift-IR on rise SHALL shift right, with jtag_tdi_i entering the MSB.
REQ-021 Update-IR on rise SHALL copy the IR shift register to the instruction register.
REQ-022 Test-Logic-Reset SHALL force the instruction register to IDCODE (5'h01).
REQ-023 Decode: 5'h01 selects IDCODE (32 bits); USER_INSTR selects USER (32 bits); all other codes, including all-ones, select BYPASS (1 bit).
REQ-024 Capture-DR on rise SHALL load the selected register: IDCODE_VAL, user_dr_i, or 1'b0 for BYPASS.
REQ-025 Shift-DR on rise SHALL shift the selected register right, with jtag_tdi_i entering the MSB.
REQ-026 Update-DR with USER selected SHALL copy the user shift register to user_dr_o and pulse user_dr_valid_o for exactly one clk_i cycle.
REQ-027 On fall, jtag_tdo_o SHALL take the LSB of the active shift register (IR in Shift-IR, selected DR in Shift-DR).
REQ-028 On fall in any other state, jtag_tdo_o SHALL take 0.
REQ-029 jtag_tdo_o SHALL change only on fall cycles, so it is stable when the server samples after TCK low.
REQ-030 rise and fall are mutually exclusive by construction; no other simultaneous-event handling is required.
REQ-031 jtag_trst_i high SHALL force Test-Logic-Reset on the next clk_i edge, regardless of TCK, and SHALL override a concurrent rise.
REQ-032 tap_reset_o SHALL be a registered decode of state == Test-Logic-Reset.

Reset
REQ-033 On rst_ni low, SHALL asynchronously set: state Test-Logic-Reset; IR IDCODE; tck_q 0; jtag_tdo_o 0; user_dr_o 0; user_dr_valid_o 0; tap_reset_o 1; shift registers 0.
REQ-034 Reset assertion mid-shift SHALL discard partial shift data without pulsing user_dr_valid_o.

Verification
REQ-035 Bench SHALL cover: TMS=1 for 5 TCK cycles from any state -> Test-Logic-Reset; tap_reset_o=1.
REQ-036 Bench SHALL cover: after reset, go to Shift-DR and shift 32 bits -> TDO sequence LSB-first = 0x10000001.
REQ-037 Bench SHALL cover: load IR=5'h1F, then shift DR with TDI=1,0,1 -> TDO=0,1,0 (one-bit bypass delay).
REQ-038 Bench SHALL cover: IR=5'h02, shift 0xDEADBEEF, then Update-DR -> user_dr_o=0xDEADBEEF; user_dr_valid_o high for exactly 1 clk_i; TDO shifts out the prior user_dr_i value.
REQ-039 Bench SHALL cover: shift IR -> TDO's first two bits are 1,0 (capture pattern 01).
REQ-040 Bench SHALL cover: jtag_trst_i=1 during Shift-DR -> Test-Logic-Reset on the next clk_i; IR=IDCODE; no valid pulse.
